// File: rtl/o_ptg_m_t2r3_pkg.sv
// o_ptg_m_t2r3_pkg: shared state codes, header constants and page
// geometry helpers for the Y-bus page transmitter and its monitor.
// Macro O_PTG_YTX_LINE_GAP_EN adds the GAP state code.
package o_ptg_m_t2r3_pkg;

    localparam logic [2:0] HDR_PKT_TYPE_PAGE = 3'b001;
    localparam logic [7:0] HDR_IMG_TYPE_RAW  = 8'h00;

    typedef logic [2:0] ytx_state_t;

    localparam ytx_state_t ST_IDLE = 3'd0;
    localparam ytx_state_t ST_LOAD = 3'd1;
    localparam ytx_state_t ST_XFER = 3'd2;
    localparam ytx_state_t ST_DONE = 3'd3;
`ifdef O_PTG_YTX_LINE_GAP_EN
    localparam ytx_state_t ST_GAP  = 3'd4;
`endif

    // Ratios above 4 are not supported and fall back to no resize.
    function automatic logic [2:0] eff_ratio(input logic [2:0] r);
        return (r > 3'd4) ? 3'd0 : r;
    endfunction

    // Component count including Z; wraps in 3 bits like the register.
    function automatic logic [2:0] comp_num_with_z(
        input logic [2:0] comp,
        input logic       z_exsit,
        input logic [1:0] z_proc
    );
        logic [2:0] cz;
        case (z_proc)
            2'b01:   cz = comp + 3'd1;
            2'b10:   cz = comp;
            default: cz = comp + {2'b00, z_exsit};
        endcase
        return cz;
    endfunction

    // Beats per line: width*cz divided by 2^r, rounded up.
    function automatic logic [17:0] beats_per_line(
        input logic [9:0] width,
        input logic [2:0] cz,
        input logic [2:0] r
    );
        logic [2:0]  re;
        logic [17:0] prod;
        logic [17:0] rnd;
        re   = eff_ratio(r);
        prod = {8'd0, width} * {15'd0, cz};
        rnd  = (18'd1 << re) - 18'd1;
        return (prod + rnd) >> re;
    endfunction

    // Lines per page: height in 32-line units, reduced by 2^r.
    function automatic logic [14:0] lines_per_page(
        input logic [9:0] height,
        input logic [2:0] r
    );
        logic [2:0] re;
        re = eff_ratio(r);
        return {5'd0, height} << (3'd5 - re);
    endfunction

endpackage

// File: rtl/o_ptg_m_t2r3_ytx_if.sv
// o_ptg_m_t2r3_ytx_if: Y-bus source/sink handshake bundle.
// Ports: tsp (valid), srdyp (ready), data, eol; master = source side.
interface o_ptg_m_t2r3_ytx_if
    import o_ptg_m_t2r3_pkg::*;
#(
    parameter int DW = 64
);

    logic          tsp;
    logic          srdyp;
    logic [DW-1:0] data;
    logic          eol;

    modport master (
        output tsp,
        output data,
        output eol,
        input  srdyp
    );

    modport slave (
        input  tsp,
        input  data,
        input  eol,
        output srdyp
    );

endinterface

// File: rtl/o_ptg_m_t2r3_ytx_skid.sv
// o_ptg_m_t2r3_ytx_skid: 2-entry registered valid/ready skid buffer.
// Ports: clk, rst_n, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module o_ptg_m_t2r3_ytx_skid
    import o_ptg_m_t2r3_pkg::*;
#(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q;
    logic [W-1:0] out_data_q;
    logic         skid_valid_q;
    logic [W-1:0] skid_data_q;
    logic         in_fire;
    logic         out_load;

    // Ready depends only on local state, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = ~skid_valid_q;
    assign in_fire   = in_valid & ~skid_valid_q;
    assign out_load  = ~out_valid_q | out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_load) begin
            if (skid_valid_q) begin
                out_data_q   <= skid_data_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_fire;
                if (in_fire) begin
                    out_data_q <= in_data;
                end
            end
        end else if (in_fire) begin
            // Output stalled: park the word so in_ready can stay registered.
            skid_data_q  <= in_data;
            skid_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/o_ptg_m_t2r3_ytx.sv
// o_ptg_m_t2r3_ytx: Y-bus page transmitter; start latches page geometry,
// then beats_max*lines_max upstream words are sent over the Y-bus.
// Ports: s_clk, rst_n, start, abort, reg_* geometry, src_valid/src_data/
// src_ready, yif (master), hdr_* header fields, busy, page_done, cfg_err.
// Macro O_PTG_YTX_LINE_GAP_EN inserts one idle GAP cycle between lines.
module o_ptg_m_t2r3_ytx
    import o_ptg_m_t2r3_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic                  s_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [14:5]           reg_page_width,
    input  logic [14:5]           reg_page_height,
    input  logic [2:0]            reg_resize_ratio,
    input  logic [2:0]            reg_img_comp_num,
    input  logic                  reg_z_exsit,
    input  logic [1:0]            reg_z_proc,
    input  logic                  src_valid,
    input  logic [DW-1:0]         src_data,
    output logic                  src_ready,
    o_ptg_m_t2r3_ytx_if.master    yif,
    output logic [7:0]            hdr_img_type,
    output logic [2:0]            hdr_pkt_type,
    output logic [11:0]           hdr_x_cord,
    output logic [11:0]           hdr_y_cord,
    output logic                  busy,
    output logic                  page_done,
    output logic                  cfg_err
);

    ytx_state_t  state_q;
    ytx_state_t  state_d;

    logic [17:0] beats_max_q;
    logic [14:0] lines_max_q;
    logic [2:0]  r_eff_q;
    logic        cfg_err_q;

    logic [17:0] beat_cnt_q;
    logic [14:0] line_cnt_q;
    logic [17:0] in_beat_q;
    logic [14:0] in_line_q;
    logic        in_done_q;

    logic [2:0]  cz;
    logic [17:0] bpl;
    logic [14:0] lpp;
    logic        cfg_bad;

    logic        st_xfer;
    logic        tsp_gate;
    logic        tsp;
    logic        beat_fire;
    logic        out_wrap;
    logic        out_last;
    logic        in_eol;

    logic          sk_in_valid;
    logic          sk_in_ready;
    logic [DW:0]   sk_in_data;
    logic          sk_out_valid;
    logic          sk_out_ready;
    logic [DW:0]   sk_out_data;

    assign cz      = comp_num_with_z(reg_img_comp_num, reg_z_exsit,
                                     reg_z_proc);
    assign bpl     = beats_per_line(reg_page_width, cz, reg_resize_ratio);
    assign lpp     = lines_per_page(reg_page_height, reg_resize_ratio);
    assign cfg_bad = (bpl == 18'd0) || (lpp == 15'd0);

    assign st_xfer = (state_q == ST_XFER);

    // Upstream side: stop taking words once the whole page is in.
    assign src_ready   = st_xfer & ~in_done_q & sk_in_ready;
    assign sk_in_valid = src_valid & src_ready;
    assign in_eol      = (in_beat_q == beats_max_q - 18'd1);
    assign sk_in_data  = {in_eol, src_data};

`ifdef O_PTG_YTX_LINE_GAP_EN
    assign tsp_gate = (state_q != ST_GAP);
`else
    assign tsp_gate = 1'b1;
`endif

    assign tsp          = sk_out_valid & tsp_gate;
    assign sk_out_ready = yif.srdyp & tsp_gate;
    assign beat_fire    = tsp & yif.srdyp;
    assign out_wrap     = (beat_cnt_q == beats_max_q - 18'd1);
    assign out_last     = (line_cnt_q == lines_max_q - 15'd1);

    assign yif.tsp  = tsp;
    assign yif.data = sk_out_data[DW-1:0];
    assign yif.eol  = sk_out_data[DW];

    o_ptg_m_t2r3_ytx_skid #(
        .W (DW + 1)
    ) u_skid (
        .clk       (s_clk),
        .rst_n     (rst_n),
        .flush     (abort),
        .in_valid  (sk_in_valid),
        .in_ready  (sk_in_ready),
        .in_data   (sk_in_data),
        .out_valid (sk_out_valid),
        .out_ready (sk_out_ready),
        .out_data  (sk_out_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = cfg_bad ? ST_IDLE : ST_XFER;
            end
            ST_XFER: begin
                if (beat_fire && out_wrap) begin
                    if (out_last) begin
                        state_d = ST_DONE;
                    end else begin
`ifdef O_PTG_YTX_LINE_GAP_EN
                        state_d = ST_GAP;
`else
                        state_d = ST_XFER;
`endif
                    end
                end
            end
`ifdef O_PTG_YTX_LINE_GAP_EN
            ST_GAP: begin
                state_d = ST_XFER;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= (state_q == ST_LOAD) & cfg_bad & ~abort;
        end
    end

    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_max_q <= '0;
            lines_max_q <= '0;
            r_eff_q     <= '0;
        end else if (state_q == ST_LOAD) begin
            beats_max_q <= bpl;
            lines_max_q <= lpp;
            r_eff_q     <= eff_ratio(reg_resize_ratio);
        end
    end

    // Two counter sets: the input side tags eol and stops intake,
    // the output side tracks completed beats for the FSM and header.
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            line_cnt_q <= '0;
            in_beat_q  <= '0;
            in_line_q  <= '0;
            in_done_q  <= 1'b0;
        end else if (state_q == ST_LOAD || abort) begin
            beat_cnt_q <= '0;
            line_cnt_q <= '0;
            in_beat_q  <= '0;
            in_line_q  <= '0;
            in_done_q  <= 1'b0;
        end else begin
            if (sk_in_valid) begin
                if (in_eol) begin
                    in_beat_q <= '0;
                    if (in_line_q == lines_max_q - 15'd1) begin
                        in_done_q <= 1'b1;
                    end else begin
                        in_line_q <= in_line_q + 15'd1;
                    end
                end else begin
                    in_beat_q <= in_beat_q + 18'd1;
                end
            end
            if (beat_fire) begin
                if (out_wrap) begin
                    beat_cnt_q <= '0;
                    line_cnt_q <= out_last ? 15'd0 : line_cnt_q + 15'd1;
                end else begin
                    beat_cnt_q <= beat_cnt_q + 18'd1;
                end
            end
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign page_done    = (state_q == ST_DONE);
    assign cfg_err      = cfg_err_q;
    assign hdr_img_type = HDR_IMG_TYPE_RAW;
    assign hdr_pkt_type = busy ? HDR_PKT_TYPE_PAGE : 3'b000;
    assign hdr_x_cord   = 12'd0;
    assign hdr_y_cord   = 12'(line_cnt_q >> (3'd5 - r_eff_q));

endmodule

// File: tb/tb_o_ptg_m_t2r3_ytx.sv
// tb_o_ptg_m_t2r3_ytx: directed scoreboard bench for the Y-bus page
// transmitter (beat/line counts, resize, backpressure, abort, reset).
module tb_o_ptg_m_t2r3_ytx;

    localparam int DW = 64;
`ifdef O_PTG_YTX_LINE_GAP_EN
    localparam int GAP_ON = 1;
`else
    localparam int GAP_ON = 0;
`endif

    logic          s_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [14:5]   reg_page_width = '0;
    logic [14:5]   reg_page_height = '0;
    logic [2:0]    reg_resize_ratio = '0;
    logic [2:0]    reg_img_comp_num = '0;
    logic          reg_z_exsit = 1'b0;
    logic [1:0]    reg_z_proc = '0;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_ready;
    logic [7:0]    hdr_img_type;
    logic [2:0]    hdr_pkt_type;
    logic [11:0]   hdr_x_cord;
    logic [11:0]   hdr_y_cord;
    logic          busy;
    logic          page_done;
    logic          cfg_err;

    o_ptg_m_t2r3_ytx_if #(.DW(DW)) yif();

    o_ptg_m_t2r3_ytx #(.DW(DW)) dut (
        .s_clk            (s_clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .reg_page_width   (reg_page_width),
        .reg_page_height  (reg_page_height),
        .reg_resize_ratio (reg_resize_ratio),
        .reg_img_comp_num (reg_img_comp_num),
        .reg_z_exsit      (reg_z_exsit),
        .reg_z_proc       (reg_z_proc),
        .src_valid        (src_valid),
        .src_data         (src_data),
        .src_ready        (src_ready),
        .yif              (yif),
        .hdr_img_type     (hdr_img_type),
        .hdr_pkt_type     (hdr_pkt_type),
        .hdr_x_cord       (hdr_x_cord),
        .hdr_y_cord       (hdr_y_cord),
        .busy             (busy),
        .page_done        (page_done),
        .cfg_err          (cfg_err)
    );

    always #5 s_clk = ~s_clk;

    int checks = 0;
    int errors = 0;
    int seq = 0;
    logic [DW-1:0] sb[$];

    function automatic logic [DW-1:0] word(input int n);
        return {32'hC0DE_0000 ^ 32'(n * 7), 32'(n)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input int w, input int h, input int r,
                       input int comp, input int zx, input int zp);
        reg_page_width   = 10'(w);
        reg_page_height  = 10'(h);
        reg_resize_ratio = 3'(r);
        reg_img_comp_num = 3'(comp);
        reg_z_exsit      = 1'(zx);
        reg_z_proc       = 2'(zp);
    endtask

    task automatic pulse_start();
        @(posedge s_clk); #1;
        start = 1'b1;
        @(posedge s_clk); #1;
        start = 1'b0;
    endtask

    // kill_mode: 0 full page, 1 abort after kill_at beats, 2 reset.
    task automatic run_page(input int nbeat, input int bpl, input int shift,
                            input int rnd, input int kill_at,
                            input int kill_mode, input int exp_gaps);
        int beats = 0;
        int gaps = 0;
        int early = 0;
        int cyc = 0;
        int ab = 0;
        bit pend = 0;
        bit fin = 0;
        bit src_f;
        bit y_f;
        bit hold_v = 0;
        logic [DW-1:0] hold_d = '0;
        logic hold_e = 1'b0;
        logic [DW-1:0] exp_d;
        sb.delete();
        src_valid = 1'b1;
        src_data = word(seq);
        yif.srdyp = 1'b1;
        pulse_start();
        while (!fin && cyc < 3000) begin
            @(negedge s_clk);
            cyc++;
            src_f = 0;
            if (ab == 2) begin
                chk("abort_tsp", yif.tsp, 0);
                chk("abort_busy", busy, 0);
                fin = 1;
            end else begin
                if (pend) begin
                    chk("page_done", page_done, 1);
                    chk("done_tsp", yif.tsp, 0);
                    fin = 1;
                end else if (page_done) begin
                    early++;
                end
                if (hold_v) begin
                    chk("hold_tsp", yif.tsp, 1);
                    chk("hold_data", yif.data, hold_d);
                    chk("hold_eol", yif.eol, hold_e);
                end
                hold_v = yif.tsp & ~yif.srdyp;
                hold_d = yif.data;
                hold_e = yif.eol;
                src_f = src_valid & src_ready;
                y_f = yif.tsp & yif.srdyp;
                if (y_f) begin
                    chk("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        exp_d = sb.pop_front();
                        chk("data", yif.data, exp_d);
                    end
                    chk("eol", yif.eol, (beats % bpl) == bpl - 1);
                    chk("ycord", hdr_y_cord, (beats / bpl) >> shift);
                    beats++;
                    if (beats == nbeat) pend = 1;
                end
                if (src_f) sb.push_back(src_data);
                if (rnd == 0 && beats > 0 && beats < nbeat && !yif.tsp)
                    gaps++;
                if (kill_mode == 2 && beats >= kill_at) begin
                    chk("pre_rst_busy", busy, 1);
                    chk("pre_rst_pkt", hdr_pkt_type, 3'b001);
                    #2 rst_n = 1'b0;
                    #1;
                    chk("rst_tsp", yif.tsp, 0);
                    chk("rst_data", yif.data, 0);
                    chk("rst_eol", yif.eol, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_src_ready", src_ready, 0);
                    chk("rst_pkt", hdr_pkt_type, 0);
                    chk("rst_ycord", hdr_y_cord, 0);
                    @(posedge s_clk); #1;
                    rst_n = 1'b1;
                    @(negedge s_clk);
                    chk("post_rst_busy", busy, 0);
                    chk("post_rst_tsp", yif.tsp, 0);
                    fin = 1;
                    src_f = 0;
                end
            end
            if (!fin) begin
                @(posedge s_clk); #1;
                if (src_f) begin
                    seq++;
                    src_data = word(seq);
                end
                yif.srdyp = (rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (ab == 1) begin
                    abort = 1'b0;
                    ab = 2;
                end else if (kill_mode == 1 && ab == 0 && beats >= kill_at) begin
                    abort = 1'b1;
                    ab = 1;
                end
            end
        end
        chk("finished", fin, 1);
        if (kill_mode == 0) begin
            chk("beats", beats, nbeat);
            chk("early_done", early, 0);
            chk("sb_left", sb.size(), 0);
            if (rnd == 0) chk("gaps", gaps, exp_gaps);
            @(negedge s_clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", page_done, 0);
            chk("idle_src_ready", src_ready, 0);
            chk("idle_pkt", hdr_pkt_type, 0);
        end else if (kill_mode == 1) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge s_clk);
                chk("abort_no_done", page_done, 0);
            end
        end
        yif.srdyp = 1'b1;
        src_f = 0;
        if (kill_mode != 0) begin
            seq++;
            src_data = word(seq);
        end
    endtask

    task automatic run_illegal();
        pulse_start();
        @(negedge s_clk);
        chk("ill_load_busy", busy, 1);
        chk("ill_load_err", cfg_err, 0);
        @(negedge s_clk);
        chk("ill_err", cfg_err, 1);
        chk("ill_busy", busy, 0);
        chk("ill_tsp", yif.tsp, 0);
        @(negedge s_clk);
        chk("ill_err_pulse", cfg_err, 0);
        chk("ill_tsp2", yif.tsp, 0);
    endtask

    initial begin
        yif.srdyp = 1'b1;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_tsp", yif.tsp, 0);
        chk("reset_src_ready", src_ready, 0);
        chk("reset_pkt", hdr_pkt_type, 0);
        chk("reset_cfg_err", cfg_err, 0);
        chk("reset_done", page_done, 0);
        @(posedge s_clk); #1;
        rst_n = 1'b1;

        cfg(1, 1, 0, 3, 1, 0);
        run_page(128, 4, 5, 0, 0, 0, GAP_ON * 31);

        cfg(1, 1, 2, 3, 1, 0);
        run_page(8, 1, 3, 0, 0, 0, GAP_ON * 7);

        cfg(1, 1, 0, 3, 1, 0);
        run_page(128, 4, 5, 1, 0, 0, 0);

        cfg(1, 1, 1, 2, 0, 1);
        run_page(32, 2, 4, 0, 0, 0, GAP_ON * 15);

        cfg(1, 2, 5, 0, 1, 3);
        run_page(64, 1, 5, 0, 0, 0, GAP_ON * 63);

        cfg(1, 1, 0, 0, 1, 2);
        run_illegal();

        cfg(1, 1, 0, 3, 1, 0);
        run_page(128, 4, 5, 0, 50, 1, 0);
        run_page(128, 4, 5, 0, 0, 0, GAP_ON * 31);

        run_page(128, 4, 5, 0, 40, 2, 0);
        run_page(128, 4, 5, 0, 0, 0, GAP_ON * 31);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
